// File: rtl/pcf8591_pkg.sv
// pcf8591_pkg: shared encodings, FSM states and channel search for the PCF8591 scan sequencer
package pcf8591_pkg;
  typedef enum logic [1:0] {
    OP_WRITE     = 2'b00,
    OP_READ_ACK  = 2'b01,
    OP_READ_NACK = 2'b10,
    OP_STOP_ONLY = 2'b11
  } cmd_op_t;
  typedef enum logic [3:0] {
    IDLE, W_ADDR, W_CTRL, W_DAC, R_ADDR, R_DUMMY, R_DATA, ERR_STOP, NEXT
  } state_t;
  localparam logic [7:0] CTRL_AIN_BASE = 8'h00;
  localparam logic [7:0] CTRL_AOE      = 8'h40;
  // {found, channel}: lowest set bit of mask at index >= lo
  function automatic logic [2:0] next_channel(input logic [3:0] mask, input logic [2:0] lo);
    next_channel = 3'b000;
    for (int i = 3; i >= 0; i--)
      if (mask[i] && 3'(i) >= lo) next_channel = {1'b1, 2'(i)};
  endfunction
endpackage

// File: rtl/pcf8591_tick_gen.sv
// pcf8591_tick_gen: sample-rate prescaler with pending-scan flag and sticky overrun
//   clk, reset (async active-low); take: FSM consumes the pending scan
//   pending: a scan is requested; overrun: a tick hit an unconsumed pending request
module pcf8591_tick_gen #(
  parameter int SAMPLE_DIV = 50000,
  parameter int TIMER_W    = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic take,
  output logic pending,
  output logic overrun
);
  logic [TIMER_W-1:0] count;
  logic tick;
  assign tick = count == TIMER_W'(SAMPLE_DIV - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      count   <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      count   <= tick ? '0 : count + TIMER_W'(1);
      pending <= tick | (pending & ~take);
      overrun <= overrun | (tick & pending & ~take);
    end
endmodule

// File: rtl/pcf8591_scan_sequencer.sv
// pcf8591_scan_sequencer: per-tick scan of enabled PCF8591 channels over a byte-level I2C master
//   clk, reset (async active-low), en_mask (channel enables, latched at scan start)
//   cmd_*: one command at a time to the I2C master; rsp_*: its completion
//   sample_*: published conversion; err_pulse: channel skipped on NACK
//   overrun: sticky tick-while-pending; busy: FSM not idle
//   PCF8591_DAC_OUT_EN: adds dac_value, sets analog output enable and writes AOUT per channel
module pcf8591_scan_sequencer import pcf8591_pkg::*; #(
  parameter logic [6:0] DEV_ADDR   = 7'h48,
  parameter int         SAMPLE_DIV = 50000,
  parameter int         TIMER_W    = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] en_mask,
`ifdef PCF8591_DAC_OUT_EN
  input  logic [7:0] dac_value,
`endif
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [1:0] cmd_op,
  output logic       cmd_start,
  output logic       cmd_stop,
  output logic [7:0] cmd_wdata,
  input  logic       rsp_valid,
  input  logic       rsp_nack,
  input  logic [7:0] rsp_rdata,
  output logic       sample_valid,
  output logic [1:0] sample_ch,
  output logic [7:0] sample_data,
  output logic       err_pulse,
  output logic       overrun,
  output logic       busy
);
  state_t state, state_n;
  logic sent, take, pending, done, nack, issue;
  logic [1:0] ch, ch_n;
  logic [3:0] mask, mask_n;
  logic [2:0] first, nxt;
  logic [7:0] ctrl, dac_byte;
`ifdef PCF8591_DAC_OUT_EN
  localparam bit DAC = 1'b1;
  assign ctrl     = CTRL_AOE | {6'd0, ch};
  assign dac_byte = dac_value;
`else
  localparam bit DAC = 1'b0;
  assign ctrl     = CTRL_AIN_BASE | {6'd0, ch};
  assign dac_byte = 8'h00;
`endif
  pcf8591_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV), .TIMER_W(TIMER_W)) u_tick (
    .clk(clk), .reset(reset), .take(take), .pending(pending), .overrun(overrun)
  );
  // sent: current command accepted, waiting for its response
  assign done  = sent & rsp_valid;
  assign nack  = done & rsp_nack;
  assign first = next_channel(en_mask, 3'd0);
  assign nxt   = next_channel(mask, {1'b0, ch} + 3'd1);
  assign busy  = state != IDLE;
  always_comb begin
    state_n   = state;
    ch_n      = ch;
    mask_n    = mask;
    take      = 1'b0;
    issue     = 1'b1;
    cmd_op    = OP_WRITE;
    cmd_start = 1'b0;
    cmd_stop  = 1'b0;
    cmd_wdata = 8'h00;
    case (state)
      IDLE: begin
        issue = 1'b0;
        if (pending) begin
          take    = 1'b1;
          mask_n  = en_mask;
          ch_n    = first[1:0];
          state_n = first[2] ? W_ADDR : IDLE;
        end
      end
      W_ADDR: begin
        cmd_start = 1'b1;
        cmd_wdata = {DEV_ADDR, 1'b0};
        if (done) state_n = nack ? ERR_STOP : W_CTRL;
      end
      W_CTRL: begin
        cmd_stop  = !DAC;
        cmd_wdata = ctrl;
        if (done) state_n = nack ? ERR_STOP : DAC ? W_DAC : R_ADDR;
      end
      W_DAC: begin
        cmd_stop  = 1'b1;
        cmd_wdata = dac_byte;
        if (done) state_n = nack ? ERR_STOP : R_ADDR;
      end
      R_ADDR: begin
        cmd_start = 1'b1;
        cmd_wdata = {DEV_ADDR, 1'b1};
        if (done) state_n = nack ? ERR_STOP : R_DUMMY;
      end
      R_DUMMY: begin
        cmd_op = OP_READ_ACK;
        if (done) state_n = R_DATA;
      end
      R_DATA: begin
        cmd_op   = OP_READ_NACK;
        cmd_stop = 1'b1;
        if (done) state_n = NEXT;
      end
      ERR_STOP: begin
        cmd_op   = OP_STOP_ONLY;
        cmd_stop = 1'b1;
        if (done) state_n = NEXT;
      end
      NEXT: begin
        issue   = 1'b0;
        ch_n    = nxt[1:0];
        state_n = nxt[2] ? W_ADDR : IDLE;
      end
      default: begin
        issue   = 1'b0;
        state_n = IDLE;
      end
    endcase
    cmd_valid = issue & ~sent;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state        <= IDLE;
      sent         <= 1'b0;
      ch           <= 2'd0;
      mask         <= 4'd0;
      sample_valid <= 1'b0;
      sample_ch    <= 2'd0;
      sample_data  <= 8'h00;
      err_pulse    <= 1'b0;
    end else begin
      state        <= state_n;
      ch           <= ch_n;
      mask         <= mask_n;
      sent         <= (cmd_valid & cmd_ready) | (sent & ~done);
      sample_valid <= done & (state == R_DATA);
      err_pulse    <= done & (state == ERR_STOP);
      if (done && state == R_DATA) begin
        sample_ch   <= ch;
        sample_data <= rsp_rdata;
      end
    end
endmodule

// File: tb/tb_pcf8591_scan_sequencer.sv
// tb_pcf8591_scan_sequencer: scoreboard bench with behavioural I2C master/PCF8591 model
module tb_pcf8591_scan_sequencer;
  localparam int DIV = 200;
  logic clk = 1'b0, reset = 1'b0;
  logic [3:0] en_mask = 4'd0;
  logic cmd_valid, cmd_ready = 1'b0, cmd_start, cmd_stop;
  logic [1:0] cmd_op;
  logic [7:0] cmd_wdata;
  logic rsp_valid = 1'b0, rsp_nack = 1'b0;
  logic [7:0] rsp_rdata = 8'h00;
  logic sample_valid, err_pulse, overrun, busy;
  logic [1:0] sample_ch;
  logic [7:0] sample_data;
`ifdef PCF8591_DAC_OUT_EN
  logic [7:0] dac_value = 8'h7F;
`endif
  int compared = 0, mismatched = 0, smp_seen = 0, err_seen = 0, err_exp = 0, nack_cnt = 0;
  bit stall = 1'b0;
  logic [11:0] cmd_q[$];
  logic [9:0] smp_q[$];
  logic [7:0] data_tbl[4] = '{8'hA5, 8'hB6, 8'hC7, 8'hD8};

  pcf8591_scan_sequencer #(.SAMPLE_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .en_mask(en_mask),
`ifdef PCF8591_DAC_OUT_EN
    .dac_value(dac_value),
`endif
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_start(cmd_start),
    .cmd_stop(cmd_stop), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_nack(rsp_nack),
    .rsp_rdata(rsp_rdata), .sample_valid(sample_valid), .sample_ch(sample_ch),
    .sample_data(sample_data), .err_pulse(err_pulse), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // expected {op,start,stop,wdata} sequence and sample for one healthy channel
  task automatic push_chan(input int c);
    cmd_q.push_back({2'b00, 1'b1, 1'b0, 8'h90});
`ifdef PCF8591_DAC_OUT_EN
    cmd_q.push_back({2'b00, 1'b0, 1'b0, 8'h40 | 8'(c)});
    cmd_q.push_back({2'b00, 1'b0, 1'b1, 8'h7F});
`else
    cmd_q.push_back({2'b00, 1'b0, 1'b1, 8'(c)});
`endif
    cmd_q.push_back({2'b00, 1'b1, 1'b0, 8'h91});
    cmd_q.push_back({2'b01, 1'b0, 1'b0, 8'h00});
    cmd_q.push_back({2'b10, 1'b0, 1'b1, 8'h00});
    smp_q.push_back({2'(c), data_tbl[c]});
  endtask

  task automatic push_nack_chan();
    cmd_q.push_back({2'b00, 1'b1, 1'b0, 8'h90});
    cmd_q.push_back({2'b11, 1'b0, 1'b1, 8'h00});
    err_exp++;
  endtask

  task automatic wait_samples(input int n, input string name);
    int t;
    t = 0;
    while (smp_seen < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check(name, smp_seen, n);
  endtask

  // master + slave: ready randomised, response 1..3 cycles after accept
  initial begin : model
    logic hs, rn;
    logic [11:0] c;
    logic [7:0] rd;
    logic [1:0] sel;
    bit outst, ctl_next;
    int lat;
    hs = 0; rn = 0; c = 0; rd = 0; sel = 0; outst = 0; ctl_next = 0; lat = 0;
    forever begin
      @(negedge clk);
      hs = cmd_valid && cmd_ready;
      c  = {cmd_op, cmd_start, cmd_stop, cmd_wdata};
      @(posedge clk);
      #1;
      rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_rdata = 8'h00;
      if (!reset) begin
        outst = 0; ctl_next = 0; cmd_ready = 1'b0;
      end else begin
        if (hs) begin
          outst = 1; lat = $urandom_range(0, 2); rn = 1'b0; rd = 8'h00;
          if (c[11:10] == 2'b00 && c[7:0] == 8'h90) begin
            if (nack_cnt != 0) begin
              nack_cnt--;
              rn = nack_cnt == 0;
            end
          end else if (c[11:10] == 2'b00 && ctl_next) sel = c[1:0];
          ctl_next = c[11:10] == 2'b00 && c[7:0] == 8'h90;
          if (c[11:10] == 2'b01) rd = 8'h11;
          if (c[11:10] == 2'b10) rd = data_tbl[sel];
        end else if (outst) begin
          if (lat == 0) begin
            rsp_valid = 1'b1; rsp_nack = rn; rsp_rdata = rd; outst = 0;
          end else lat--;
        end
        cmd_ready = !stall && ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin : monitor
    bit pstall;
    logic [11:0] pc;
    pstall = 0; pc = 0;
    forever begin
      @(negedge clk);
      if (!reset) pstall = 0;
      else begin
        if (pstall) check("cmd_hold", {cmd_valid, cmd_op, cmd_start, cmd_stop, cmd_wdata}, {1'b1, pc});
        if (cmd_valid && cmd_ready) begin
          if (cmd_q.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL cmd_extra: got %h expected no command", {cmd_op, cmd_start, cmd_stop, cmd_wdata});
          end else check("cmd", {cmd_op, cmd_start, cmd_stop, cmd_wdata}, cmd_q.pop_front());
        end
        pstall = cmd_valid && !cmd_ready;
        pc = {cmd_op, cmd_start, cmd_stop, cmd_wdata};
        if (sample_valid) begin
          smp_seen++;
          if (smp_q.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL sample_extra: got ch%0d %h expected no sample", sample_ch, sample_data);
          end else check("sample", {sample_ch, sample_data}, smp_q.pop_front());
        end
        if (err_pulse) err_seen++;
      end
    end
  end

  initial begin : stim
    int t;
    en_mask = 4'b0001;
    repeat (3) @(negedge clk);
    check("reset_out", {cmd_valid, cmd_op, cmd_start, cmd_stop, cmd_wdata, sample_valid, sample_ch,
                        sample_data, err_pulse, overrun, busy}, 0);
    push_chan(0);
    #2 reset = 1'b1;
    wait_samples(1, "t1_samples");
    push_chan(1); push_chan(3);
    en_mask = 4'b1010;
    wait_samples(3, "t2_samples");
    check("t2_overrun", overrun, 0);
    nack_cnt = 2;
    push_chan(0); push_nack_chan(); push_chan(0); push_chan(1);
    en_mask = 4'b0011;
    wait_samples(6, "t3_samples");
    check("t3_err", err_seen, 1);
    check("t3_overrun", overrun, 0);
    stall = 1'b1;
    en_mask = 4'b0001;
    push_chan(0); push_chan(0);
    t = 0;
    while (!cmd_valid && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("t4_stall_start", cmd_valid, 1);
    repeat (3 * DIV) @(negedge clk);
    check("t4_overrun", overrun, 1);
    check("t4_waddr_held", {cmd_valid, cmd_op, cmd_start, cmd_stop, cmd_wdata}, {1'b1, 2'b00, 1'b1, 1'b0, 8'h90});
    stall = 1'b0;
    wait_samples(7, "t4_first_scan");
    t = 0;
    while (!cmd_valid && t < 6) begin
      @(negedge clk);
      t++;
    end
    check("t4_pending_scan", cmd_valid, 1);
    en_mask = 4'b0000;
    wait_samples(8, "t4_second_scan");
    en_mask = 4'b0001;
    push_chan(0);
    t = 0;
    while (!(cmd_valid && cmd_op == 2'b01) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("t5_in_rdummy", {cmd_valid, cmd_op}, {1'b1, 2'b01});
    #2 reset = 1'b0;
    #1;
    check("t5_reset_out", {cmd_valid, cmd_op, cmd_start, cmd_stop, cmd_wdata, sample_valid, sample_ch,
                           sample_data, err_pulse, overrun, busy}, 0);
    cmd_q.delete();
    smp_q.delete();
    repeat (3) @(negedge clk);
    push_chan(0);
    #2 reset = 1'b1;
    t = 0;
    while (!cmd_valid && t < 2 * DIV) begin
      @(negedge clk);
      t++;
    end
    check("t5_first_cmd_cycle", t, DIV + 1);
    check("t5_first_cmd", {cmd_op, cmd_start, cmd_stop, cmd_wdata}, {2'b00, 1'b1, 1'b0, 8'h90});
    wait_samples(9, "t5_samples");
    check("t5_overrun", overrun, 0);
    check("err_total", err_seen, err_exp);
    check("cmd_q_left", cmd_q.size(), 0);
    check("smp_q_left", smp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1);
  end
endmodule
